ps2_key_buffer: RTL and testbench

- Keyboard front end that sits directly upstream of the memory subsystem's keyboard port (address 0xFFFFFFFF).
- Receives PS/2 frames from the keyboard pins, checks each frame, and filters out break and extended-prefix codes.
- Queues make codes in a small FIFO and presents the oldest one on pressed_key.
- The memory subsystem pops that entry by pulsing clean_key_buffer, which it does on each CPU read of the key address.

---
 rtl/ps2_key_buffer.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_key_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_buffer.sv
// PS/2 keyboard receiver with break/extend filtering and a scancode FIFO.
// Oldest make code is shown on pressed_key; clean_key_buffer pops it.
module ps2_key_buffer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 4000,
  parameter bit FILTER_BREAK   = 1'b1
) (
  input  logic       CLK_CPU,
  input  logic       RST_N,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       clean_key_buffer,
  output logic [7:0] pressed_key,
  output logic       key_valid,
  output logic       overflow,
  output logic       frame_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_prev;
  logic       fall;
  logic       bit_in;

  always_ff @(posedge CLK_CPU or negedge RST_N) begin
    if (!RST_N) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign bit_in = dat_sync[1];

  state_t          state, state_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      shreg, shreg_n;
  logic            parity_ok, parity_ok_n;
  logic [WW-1:0]   wdog, wdog_n;
  logic            rx_valid, rx_valid_n;
  logic            err_n;
  logic            timeout;

  always_ff @(posedge CLK_CPU or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      parity_ok   <= 1'b0;
      wdog        <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      parity_ok   <= parity_ok_n;
      wdog        <= wdog_n;
      rx_valid    <= rx_valid_n;
      frame_error <= err_n;
    end
  end

  // Watchdog only runs inside a frame; any falling edge restarts it.
  assign timeout = (state != IDLE) && !fall &&
                   (wdog == WW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    parity_ok_n = parity_ok;
    rx_valid_n  = 1'b0;
    err_n       = 1'b0;
    if (state == IDLE || fall) begin
      wdog_n = '0;
    end else begin
      wdog_n = wdog + WW'(1);
    end
    unique case (state)
      IDLE: begin
        if (fall && !bit_in) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_n   = {bit_in, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          parity_ok_n = ^{shreg, bit_in};
          state_n     = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (bit_in && parity_ok) begin
            rx_valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      state_n = IDLE;
      err_n   = 1'b1;
      wdog_n  = '0;
    end
  end

  logic brk, brk_n;
  logic ext, ext_n;
  logic push;

  always_ff @(posedge CLK_CPU or negedge RST_N) begin
    if (!RST_N) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else begin
      brk <= brk_n;
      ext <= ext_n;
    end
  end

  // The byte after an F0 is a release code and is swallowed.
  always_comb begin
    brk_n = brk;
    ext_n = ext;
    push  = 1'b0;
    if (rx_valid) begin
      if (!FILTER_BREAK) begin
        push = 1'b1;
      end else if (shreg == 8'hE0) begin
        ext_n = 1'b1;
      end else if (shreg == 8'hF0) begin
        brk_n = 1'b1;
      end else if (brk) begin
        brk_n = 1'b0;
        ext_n = 1'b0;
      end else begin
        ext_n = 1'b0;
        push  = 1'b1;
      end
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          wr;
  logic          drop;

  assign full = (count == CW'(FIFO_DEPTH));
  assign pop  = clean_key_buffer && (count != '0);
  assign wr   = push && (!full || pop);
  assign drop = push && full && !pop;

  always_ff @(posedge CLK_CPU or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !wr) begin
        count <= count - CW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (pop) begin
        overflow <= 1'b0;
      end
    end
  end

  assign key_valid   = (count != '0);
  assign pressed_key = key_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_ps2_key_buffer.sv
// Bench for ps2_key_buffer: vector table, corner sequences, random frames
// checked against a queue-based keyboard model.
module tb_ps2_key_buffer;

  localparam int DEPTH = 8;
  localparam int TO    = 300;
  localparam int HALF  = 20;

  logic       CLK_CPU = 1'b0;
  logic       RST_N = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       clean_key_buffer = 1'b0;
  logic [7:0] pressed_key;
  logic       key_valid;
  logic       overflow;
  logic       frame_error;

  ps2_key_buffer #(
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_BREAK(1'b1)
  ) dut (
    .CLK_CPU(CLK_CPU),
    .RST_N(RST_N),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .clean_key_buffer(clean_key_buffer),
    .pressed_key(pressed_key),
    .key_valid(key_valid),
    .overflow(overflow),
    .frame_error(frame_error)
  );

  always #5 CLK_CPU = ~CLK_CPU;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;

  always @(negedge CLK_CPU) if (frame_error === 1'b1) err_cnt++;

  initial begin
    #800000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  logic [7:0] mq[$];
  bit m_ov, m_brk, m_ext;

  function automatic void m_reset();
    mq.delete();
    m_ov = 0;
    m_brk = 0;
    m_ext = 0;
  endfunction

  function automatic void m_frame(logic [7:0] c, bit ok);
    if (!ok) return;
    if (c == 8'hE0) m_ext = 1;
    else if (c == 8'hF0) m_brk = 1;
    else if (m_brk) begin
      m_brk = 0;
      m_ext = 0;
    end else begin
      m_ext = 0;
      if (mq.size() < DEPTH) mq.push_back(c);
      else m_ov = 1;
    end
  endfunction

  function automatic void m_pop();
    if (mq.size() > 0) begin
      void'(mq.pop_front());
      m_ov = 0;
    end
  endfunction

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic chk_model(string n);
    chk({n, "_kv"}, 32'(key_valid), 32'(mq.size() != 0));
    chk({n, "_pk"}, 32'(pressed_key), mq.size() != 0 ? 32'(mq[0]) : 32'h0);
    chk({n, "_ov"}, 32'(overflow), 32'(m_ov));
  endtask

  task automatic send_bit(bit b);
    ps2_data = b;
    repeat (HALF) @(negedge CLK_CPU);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge CLK_CPU);
    ps2_clk = 1'b1;
  endtask

  task automatic frame(logic [7:0] c, bit bad_par, bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(c[i]);
    send_bit((~^c) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge CLK_CPU);
    m_frame(c, !bad_par && !bad_stop);
  endtask

  task automatic pop();
    @(negedge CLK_CPU);
    clean_key_buffer = 1'b1;
    @(negedge CLK_CPU);
    clean_key_buffer = 1'b0;
    @(negedge CLK_CPU);
    m_pop();
  endtask

  typedef struct {
    bit         is_pop;
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    bit         kv;
    logic [7:0] pk;
    bit         ov;
    int         errs;
  } vec_t;

  vec_t vt[$];

  initial begin
    int e0;
    vt.push_back('{0, 8'h1C, 0, 0, 1, 8'h1C, 0, 0});
    vt.push_back('{1, 8'h00, 0, 0, 0, 8'h00, 0, 0});
    vt.push_back('{0, 8'h1C, 1, 0, 0, 8'h00, 0, 1});
    vt.push_back('{0, 8'hF0, 0, 0, 0, 8'h00, 0, 0});
    vt.push_back('{0, 8'h1C, 0, 0, 0, 8'h00, 0, 0});
    vt.push_back('{0, 8'h32, 0, 0, 1, 8'h32, 0, 0});
    vt.push_back('{0, 8'hE0, 0, 0, 1, 8'h32, 0, 0});
    vt.push_back('{0, 8'h75, 0, 0, 1, 8'h32, 0, 0});
    vt.push_back('{1, 8'h00, 0, 0, 1, 8'h75, 0, 0});
    vt.push_back('{1, 8'h00, 0, 0, 0, 8'h00, 0, 0});
    vt.push_back('{0, 8'h55, 0, 1, 0, 8'h00, 0, 1});
    vt.push_back('{1, 8'h00, 0, 0, 0, 8'h00, 0, 0});

    m_reset();
    repeat (3) @(negedge CLK_CPU);
    chk("rst_kv", 32'(key_valid), 0);
    chk("rst_pk", 32'(pressed_key), 0);
    chk("rst_ov", 32'(overflow), 0);
    chk("rst_fe", 32'(frame_error), 0);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK_CPU);

    foreach (vt[k]) begin
      e0 = err_cnt;
      if (vt[k].is_pop) pop();
      else frame(vt[k].code, vt[k].bad_par, vt[k].bad_stop);
      chk($sformatf("vec%0d_kv", k), 32'(key_valid), 32'(vt[k].kv));
      chk($sformatf("vec%0d_pk", k), 32'(pressed_key), 32'(vt[k].pk));
      chk($sformatf("vec%0d_ov", k), 32'(overflow), 32'(vt[k].ov));
      chk($sformatf("vec%0d_err", k), 32'(err_cnt - e0), 32'(vt[k].errs));
    end

    for (int i = 1; i <= 9; i++) frame(8'(i), 0, 0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head", 32'(pressed_key), 32'h01);
    chk("ovf_kv", 32'(key_valid), 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_pop%0d_pk", i), 32'(pressed_key), 32'(i));
      pop();
      chk($sformatf("ovf_pop%0d_ov", i), 32'(overflow), 0);
    end
    chk("ovf_end_kv", 32'(key_valid), 0);

    e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (TO + HALF) @(negedge CLK_CPU);
    chk("tmo_err", 32'(err_cnt - e0), 1);
    chk("tmo_kv", 32'(key_valid), 0);
    frame(8'h2A, 0, 0);
    chk("tmo_next_pk", 32'(pressed_key), 32'h2A);
    chk("tmo_next_err", 32'(err_cnt - e0), 1);
    pop();

    frame(8'h11, 0, 0);
    frame(8'h22, 0, 0);
    frame(8'h33, 0, 0);
    chk("rstq_pk", 32'(pressed_key), 32'h11);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge CLK_CPU);
    RST_N = 1'b0;
    #1;
    chk("rstq_kv", 32'(key_valid), 0);
    chk("rstq_pk0", 32'(pressed_key), 0);
    chk("rstq_ov", 32'(overflow), 0);
    chk("rstq_fe", 32'(frame_error), 0);
    repeat (2) @(negedge CLK_CPU);
    RST_N = 1'b1;
    m_reset();
    repeat (5) @(negedge CLK_CPU);
    frame(8'h45, 0, 0);
    chk("rstq_45_pk", 32'(pressed_key), 32'h45);
    chk("rstq_45_kv", 32'(key_valid), 1);
    pop();
    chk("rstq_only", 32'(key_valid), 0);

    for (int it = 0; it < 36; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        int np;
        np = $urandom_range(1, 3);
        for (int p = 0; p < np; p++) pop();
        chk_model($sformatf("rnd%0d_pop", it));
      end else begin
        logic [7:0] c;
        bit bp, bs;
        int sel;
        sel = $urandom_range(0, 5);
        c = (sel == 0) ? 8'hF0 : (sel == 1) ? 8'hE0 : 8'($urandom_range(1, 255));
        bp = ($urandom_range(0, 7) == 0);
        bs = !bp && ($urandom_range(0, 9) == 0);
        e0 = err_cnt;
        frame(c, bp, bs);
        chk_model($sformatf("rnd%0d_frm", it));
        chk($sformatf("rnd%0d_err", it), 32'(err_cnt - e0), 32'(bp || bs));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
